vslc_servo_pwm: RTL and testbench



---
 rtl/vslc_pkg.sv | 34 +++
 rtl/vslc_prescaler.sv | 34 +++
 rtl/vslc_servo_pwm.sv | 117 +++++++++++
 tb/tb_vslc_servo_pwm.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/vslc_pkg.sv
// Shared constants and helpers for the VSLC peripherals.
// Holds the servo PWM defaults and the pulse-width computation with its clamp.
package vslc_pkg;

  localparam int unsigned SERVO_CLK_DIV     = 9;
  localparam int unsigned SERVO_FRAME_TICKS = 20000;
  localparam int unsigned SERVO_MIN_TICKS   = 1000;
  localparam int unsigned SERVO_STEP_TICKS  = 4;
  localparam int unsigned SERVO_RESET_POS   = 128;

  // Frame counter width; FRAME_TICKS is limited to 32767.
  localparam int unsigned SERVO_FRAME_W     = 15;

  // Pulse width in ticks for a position.
  // The sum is formed in 17 bits. It is clamped to frame_ticks-1 so that
  // every frame keeps at least one low tick.
  function automatic logic [14:0] servo_width(
    input logic [7:0]  pos,
    input int unsigned min_ticks,
    input int unsigned step_ticks,
    input int unsigned frame_ticks
  );
    logic [16:0] raw;
    logic [16:0] lim;
    raw = 17'(min_ticks) + (17'(pos) * 17'(step_ticks));
    lim = 17'(frame_ticks);
    if (raw >= lim) begin
      servo_width = 15'(frame_ticks - 32'd1);
    end else begin
      servo_width = raw[14:0];
    end
  endfunction

endpackage

// File: rtl/vslc_prescaler.sv
// Clock prescaler shared by the VSLC timebases.
// It emits a one-clock tick every DIV+1 clocks. clr parks the count at 0 and
// suppresses the tick.
module vslc_prescaler #(
  parameter int unsigned DIV = 9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (DIV < 1) ? 1 : $clog2(DIV + 1);

  logic [CW-1:0] pre_cnt_r;
  logic          at_top_s;

  assign at_top_s = (pre_cnt_r == CW'(DIV));
  assign tick     = at_top_s & ~clr;

  // Count 0..DIV and wrap on the tick; clr holds the count at 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_r <= '0;
    end else if (clr) begin
      pre_cnt_r <= '0;
    end else if (at_top_s) begin
      pre_cnt_r <= '0;
    end else begin
      pre_cnt_r <= pre_cnt_r + CW'(1'b1);
    end
  end

endmodule

// File: rtl/vslc_servo_pwm.sv
// Hobby-servo PWM generator.
// It produces one pulse per frame, with a width of MIN_TICKS + pos*STEP_TICKS
// ticks. Positions are double-buffered: a write lands in pend_pos and moves to
// act_pos only at a frame load, so a pulse is never truncated mid-frame.
module vslc_servo_pwm
  import vslc_pkg::*;
#(
  parameter int unsigned CLK_DIV     = SERVO_CLK_DIV,
  parameter int unsigned FRAME_TICKS = SERVO_FRAME_TICKS,
  parameter int unsigned MIN_TICKS   = SERVO_MIN_TICKS,
  parameter int unsigned STEP_TICKS  = SERVO_STEP_TICKS,
  parameter int unsigned RESET_POS   = SERVO_RESET_POS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       wr_i,
  input  logic [7:0] pos_i,
  output logic       servo_o,
  output logic       frame_o,
  output logic       upd_pending_o
);

  logic                     tick_s;
  logic                     clr_s;
  logic                     last_s;
  logic                     load_s;
  logic [14:0]              width_s;

  logic                     run_r;
  logic [SERVO_FRAME_W-1:0] frame_cnt_r;
  logic [7:0]               pend_pos_r;
  logic [7:0]               act_pos_r;
  logic                     upd_pending_r;
  logic                     servo_r;
  logic                     frame_r;

  // The first enabled clock after reset or after a disable is itself a frame
  // load. The prescaler is held in that clock too, so the first frame_cnt=0
  // slot lasts a full CLK_DIV+1 clocks and the first pulse has full width.
  assign clr_s   = ~(en_i & run_r);
  assign last_s  = (frame_cnt_r == SERVO_FRAME_W'(FRAME_TICKS - 32'd1));
  assign load_s  = en_i & (~run_r | (tick_s & last_s));
  assign width_s = servo_width(act_pos_r, MIN_TICKS, STEP_TICKS, FRAME_TICKS);

  vslc_prescaler #(
    .DIV (CLK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_s),
    .tick  (tick_s)
  );

  // Frame counter: advance on each tick while running, and park at 0 when
  // disabled or in the load clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_r       <= 1'b0;
      frame_cnt_r <= '0;
    end else begin
      run_r <= en_i;
      if (!en_i || !run_r) begin
        frame_cnt_r <= '0;
      end else if (tick_s) begin
        frame_cnt_r <= last_s ? '0 : frame_cnt_r + SERVO_FRAME_W'(1'b1);
      end else begin
        frame_cnt_r <= frame_cnt_r;
      end
    end
  end

  // Double buffer: writes go to pend_pos and the frame load copies them to
  // act_pos. A write in the load clock wins over the clear of upd_pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_pos_r    <= 8'(RESET_POS);
      act_pos_r     <= 8'(RESET_POS);
      upd_pending_r <= 1'b0;
    end else begin
      if (wr_i) begin
        pend_pos_r <= pos_i;
      end else begin
        pend_pos_r <= pend_pos_r;
      end
      if (load_s) begin
        act_pos_r <= pend_pos_r;
      end else begin
        act_pos_r <= act_pos_r;
      end
      if (wr_i) begin
        upd_pending_r <= 1'b1;
      end else if (load_s) begin
        upd_pending_r <= 1'b0;
      end else begin
        upd_pending_r <= upd_pending_r;
      end
    end
  end

  // Registered outputs: the PWM level, and a strobe in the clock after each
  // frame load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      servo_r <= 1'b0;
      frame_r <= 1'b0;
    end else begin
      servo_r <= en_i & run_r & (frame_cnt_r < width_s);
      frame_r <= load_s;
    end
  end

  assign servo_o       = servo_r;
  assign frame_o       = frame_r;
  assign upd_pending_o = upd_pending_r;

endmodule

// File: tb/tb_vslc_servo_pwm.sv
// Directed self-checking bench for vslc_servo_pwm.
// It uses CLK_DIV=0, FRAME_TICKS=100, MIN_TICKS=10, STEP_TICKS=1 and
// RESET_POS=128. Expected widths are hand-computed as min(10+pos, 99).
module tb_vslc_servo_pwm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_i;
  logic       wr_i;
  logic [7:0] pos_i;
  logic       servo_o;
  logic       frame_o;
  logic       upd_pending_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vslc_servo_pwm #(
    .CLK_DIV     (0),
    .FRAME_TICKS (100),
    .MIN_TICKS   (10),
    .STEP_TICKS  (1),
    .RESET_POS   (128)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en_i          (en_i),
    .wr_i          (wr_i),
    .pos_i         (pos_i),
    .servo_o       (servo_o),
    .frame_o       (frame_o),
    .upd_pending_o (upd_pending_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Entered at the negedge where frame_o=1 (frame_cnt=0). Runs one full frame
  // with optional writes at frame_cnt=wa and frame_cnt=wb, and checks the pulse
  // width, that there is no stray strobe, and that the next strobe comes 100
  // clocks later.
  task automatic run_frame(input string tag, input int exp_w,
                           input int wa, input logic [7:0] va,
                           input int wb, input logic [7:0] vb);
    int hi    = 0;
    int extra = 0;
    for (int j = 1; j <= 100; j++) begin
      @(negedge clk);
      wr_i = 1'b0;
      if (servo_o === 1'b1) hi++;
      if (j < 100 && frame_o !== 1'b0) extra++;
      if (wa > 0 && (j == wa + 1 || j == 99)) check_eq({tag, "_pend"}, 32'(upd_pending_o), 32'd1);
      if (j == wa) begin
        wr_i  = 1'b1;
        pos_i = va;
      end else if (j == wb) begin
        wr_i  = 1'b1;
        pos_i = vb;
      end
    end
    check_eq({tag, "_width"}, 32'(hi), 32'(exp_w));
    check_eq({tag, "_stray"}, 32'(extra), 32'd0);
    check_eq({tag, "_period"}, 32'(frame_o), 32'd1);
  endtask

  initial begin
    rst_n = 1'b1;
    en_i  = 1'b1;
    wr_i  = 1'b0;
    pos_i = 8'd0;
    #1 rst_n = 1'b0;

    // Reset is held with the output enabled, so all outputs must stay low
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_servo", 32'(servo_o), 32'd0);
      check_eq("rst_frame", 32'(frame_o), 32'd0);
      check_eq("rst_upd", 32'(upd_pending_o), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("first_frame", 32'(frame_o), 32'd1);
    check_eq("first_servo", 32'(servo_o), 32'd0);

    // Centre position 128: 138 is clamped to 99
    run_frame("rst", 99, -1, 8'd0, -1, 8'd0);

    // A write of 20 mid-frame leaves the current pulse alone and applies next frame
    run_frame("mid", 99, 50, 8'd20, -1, 8'd0);
    check_eq("mid_load_clr", 32'(upd_pending_o), 32'd0);

    // Width 30; write 0 mid-frame, then write 5 in the wrap clock
    run_frame("w30", 30, 50, 8'd0, 99, 8'd5);
    check_eq("clash_pend", 32'(upd_pending_o), 32'd1);
    run_frame("w10", 10, -1, 8'd0, -1, 8'd0);
    check_eq("w10_clr", 32'(upd_pending_o), 32'd0);
    run_frame("w15", 15, -1, 8'd0, -1, 8'd0);

    // Disable at frame_cnt=3, mid-pulse
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      if (j == 3) begin
        check_eq("dis_pre", 32'(servo_o), 32'd1);
        en_i = 1'b0;
      end
    end
    @(negedge clk);
    check_eq("dis_next", 32'(servo_o), 32'd0);
    check_eq("dis_frame", 32'(frame_o), 32'd0);
    wr_i  = 1'b1;
    pos_i = 8'd40;
    @(negedge clk);
    wr_i = 1'b0;
    check_eq("dis_wr", 32'(upd_pending_o), 32'd1);
    repeat (3) @(negedge clk);
    check_eq("dis_hold", 32'(servo_o), 32'd0);
    en_i = 1'b1;
    @(negedge clk);
    check_eq("reen_frame", 32'(frame_o), 32'd1);
    check_eq("reen_servo", 32'(servo_o), 32'd0);
    check_eq("reen_clr", 32'(upd_pending_o), 32'd0);
    run_frame("reen", 50, 10, 8'd255, -1, 8'd0);
    check_eq("reen_end_clr", 32'(upd_pending_o), 32'd0);

    // 255 clamps to 99 high and 1 low
    run_frame("clamp", 99, -1, 8'd0, -1, 8'd0);

    // Async reset at frame_cnt=5 with a pending write of 50
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      wr_i = 1'b0;
      if (j == 2) begin
        wr_i  = 1'b1;
        pos_i = 8'd50;
      end
    end
    check_eq("arst_pre", 32'(servo_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_drop", 32'(servo_o), 32'd0);
    check_eq("arst_upd", 32'(upd_pending_o), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("arst_hold", 32'(servo_o), 32'd0);
      check_eq("arst_frame", 32'(frame_o), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("arst_first", 32'(frame_o), 32'd1);
    // The position returns to 128 (width 99), not the pending 50 (width 60)
    run_frame("post_rst", 99, -1, 8'd0, -1, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
